// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;
  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == LEN_BYTE ? 3'd1 : len == LEN_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM requests onto a byte-wide RAM bus, one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit FAIR_ARB   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_len_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  input  logic [7:0]            ram_din_i
);
  state_e                state_q, state_d;
  owner_e                owner_q, owner_d, last_q, last_d;
  logic [2:0]            cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wbuf_q, wbuf_d, rbuf_q, rbuf_d;
  logic                  pick_mem;
  logic [1:0]            rd_idx;
  always_comb begin
    pick_mem    = mem_req_i && (!if_req_i || !FAIR_ARB || last_q == OWN_IF);
    rd_idx      = cnt_q[1:0] - 2'd1;
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    if_data_o   = '0;
    if_done_o   = 1'b0;
    mem_rdata_o = '0;
    mem_done_o  = 1'b0;
    ram_addr_o  = '0;
    ram_dout_o  = '0;
    ram_wr_o    = 1'b0;
    case (state_q)
      ST_IDLE: if (if_req_i || mem_req_i) begin
        owner_d = pick_mem ? OWN_MEM : OWN_IF;
        base_d  = pick_mem ? mem_addr_i : if_addr_i;
        len_d   = pick_mem ? len_bytes(mem_len_i) : 3'd4;
        wbuf_d  = mem_wdata_i;
        rbuf_d  = '0;
        cnt_d   = '0;
        state_d = (pick_mem && mem_we_i) ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        // ram_din_i lags the address by one cycle, so cnt=k captures byte k-1
        if (cnt_q < len_q) ram_addr_o = base_q + ADDR_WIDTH'(cnt_q);
        if (cnt_q != 3'd0) rbuf_d[{rd_idx, 3'b000} +: 8] = ram_din_i;
        cnt_d   = cnt_q == len_q ? cnt_q : cnt_q + 3'd1;
        state_d = cnt_q == len_q ? ST_DONE : ST_READ;
      end
      ST_WRITE: begin
        ram_wr_o   = 1'b1;
        ram_addr_o = base_q + ADDR_WIDTH'(cnt_q);
        ram_dout_o = wbuf_q[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d      = cnt_q + 3'd1;
        state_d    = cnt_q == len_q - 3'd1 ? ST_DONE : ST_WRITE;
      end
      ST_DONE: begin
        if_done_o   = owner_q == OWN_IF;
        if_data_o   = owner_q == OWN_IF ? rbuf_q : '0;
        mem_done_o  = owner_q == OWN_MEM;
        mem_rdata_o = owner_q == OWN_MEM ? rbuf_q : '0;
        last_d      = owner_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl, one instance per arbitration mode sharing a RAM model.
module tb_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, mem_req = 0, mem_we = 0, f_if_req = 0, f_mem_req = 0, f_mem_we = 0;
  logic [1:0] mem_len = 0, f_mem_len = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, f_if_addr = 0, f_mem_addr = 0, f_mem_wdata = 0;
  logic [31:0] if_data, mem_rdata, ram_addr, f_if_data, f_mem_rdata, f_ram_addr;
  logic if_done, mem_done, ram_wr, f_if_done, f_mem_done, f_ram_wr;
  logic [7:0] ram_dout, f_ram_dout, ram_din, f_ram_din;
  logic [7:0] ram [4096];
  logic pl_we = 0;
  logic [11:0] pl_a = 0;
  logic [7:0] pl_d = 0;
  logic [31:0] sb [4][$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_ctrl #(.ADDR_WIDTH(32), .FAIR_ARB(1'b0)) dut (
    .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_done_o(mem_done), .ram_addr_o(ram_addr), .ram_dout_o(ram_dout),
    .ram_wr_o(ram_wr), .ram_din_i(ram_din));
  mem_ctrl #(.ADDR_WIDTH(32), .FAIR_ARB(1'b1)) dut_fair (
    .clk(clk), .rst(rst), .if_req_i(f_if_req), .if_addr_i(f_if_addr), .if_data_o(f_if_data), .if_done_o(f_if_done),
    .mem_req_i(f_mem_req), .mem_we_i(f_mem_we), .mem_len_i(f_mem_len), .mem_addr_i(f_mem_addr), .mem_wdata_i(f_mem_wdata),
    .mem_rdata_o(f_mem_rdata), .mem_done_o(f_mem_done), .ram_addr_o(f_ram_addr), .ram_dout_o(f_ram_dout),
    .ram_wr_o(f_ram_wr), .ram_din_i(f_ram_din));
  always @(posedge clk) begin
    ram_din <= ram[ram_addr[11:0]];
    f_ram_din <= ram[f_ram_addr[11:0]];
    if (pl_we) ram[pl_a] <= pl_d;
    if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    if (f_ram_wr) ram[f_ram_addr[11:0]] <= f_ram_dout;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic sb_pop(input int key, input logic [31:0] act, input string tag);
    chk({tag, "_pending"}, 32'(sb[key].size() != 0), 32'd1);
    if (sb[key].size() != 0) chk(tag, act, sb[key].pop_front());
  endtask
  always @(negedge clk) if (!rst) begin
    if (if_done) sb_pop(0, if_data, "if_data");
    if (mem_done) sb_pop(1, mem_rdata, "mem_data");
    if (f_if_done) sb_pop(2, f_if_data, "f_if_data");
    if (f_mem_done) sb_pop(3, f_mem_rdata, "f_mem_data");
  end
  function automatic logic [31:0] model_rd(input logic [31:0] a, input int nb);
    logic [31:0] d = '0;
    logic [31:0] p;
    for (int k = 0; k < nb; k++) begin
      p = a + 32'(k);
      d[8*k +: 8] = ram[p[11:0]];
    end
    return d;
  endfunction
  task automatic poke(input logic [11:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pl_a = a + 12'(k);
      pl_d = w[8*k +: 8];
      pl_we = 1'b1;
    end
    @(negedge clk);
    pl_we = 1'b0;
  endtask
  task automatic access(input bit fair, input bit is_mem, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit chk_bus,
                        input int exp_lat, input string tag);
    int nb = !is_mem ? 4 : len == 2'b00 ? 1 : len == 2'b01 ? 2 : 4;
    int n = 0;
    bit done = 0;
    sb[{fair, is_mem}].push_back(we ? 32'h0 : model_rd(addr, nb));
    if (fair && is_mem) begin f_mem_req = 1; f_mem_we = we; f_mem_len = len; f_mem_addr = addr; f_mem_wdata = wdata; end
    else if (fair) begin f_if_req = 1; f_if_addr = addr; end
    else if (is_mem) begin mem_req = 1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      done = fair ? (is_mem ? f_mem_done : f_if_done) : (is_mem ? mem_done : if_done);
      if (chk_bus && n <= nb) begin
        chk({tag, "_addr"}, ram_addr, addr + 32'(n - 1));
        chk({tag, "_wr"}, ram_wr, we);
        if (we) chk({tag, "_dout"}, ram_dout, wdata[8*(n-1) +: 8]);
      end
    end
    if (fair && is_mem) f_mem_req = 0;
    else if (fair) f_if_req = 0;
    else if (is_mem) mem_req = 0;
    else if_req = 0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, n, exp_lat);
  endtask
  initial begin
    logic [7:0] pre;
    int pulses, dcyc;
    repeat (3) @(negedge clk);
    chk("rst_if_done", if_done, 0);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_mem_data", mem_rdata, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_dout", ram_dout, 0);
    chk("rst_f_ram_wr", f_ram_wr, 0);
    poke(12'h100, 32'h10111213);
    poke(12'h104, 32'hCAFEF00D);
    poke(12'h200, 32'hDEADBEEF);
    poke(12'h000, 32'h5A5A5A12);
    poke(12'hFFC, 32'h34000000);
    poke(12'h300, 32'h77000000);
    poke(12'h400, 32'h87654321);
    poke(12'h500, 32'h0BADC0DE);
    poke(12'h600, 32'hFFFFFFFF);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_model", model_rd(32'h100, 4), 32'h10111213);
    access(0, 0, 0, 2'b11, 32'h100, 32'h0, 1, 6, "t1_if");
    @(negedge clk);
    access(0, 1, 1, 2'b00, 32'h2001, 32'hAABBCCDD, 1, 2, "t2_wr");
    @(negedge clk);
    chk("t2_ram", ram[12'h001], 8'hDD);
    chk("t2_next_byte", ram[12'h002], 8'h5A);
    fork
      access(0, 1, 0, 2'b11, 32'h104, 32'h0, 1, 6, "t3_mem");
      access(0, 0, 0, 2'b11, 32'h200, 32'h0, 0, 13, "t3_if");
    join
    @(negedge clk);
    fork
      access(1, 1, 0, 2'b11, 32'h104, 32'h0, 0, 6, "f_tie_mem");
      access(1, 0, 0, 2'b11, 32'h200, 32'h0, 0, 13, "f_tie_if");
    join
    @(negedge clk);
    access(1, 1, 0, 2'b00, 32'h100, 32'h0, 0, 3, "f_solo");
    @(negedge clk);
    fork
      access(1, 0, 0, 2'b11, 32'h200, 32'h0, 0, 6, "f_if_first");
      access(1, 1, 0, 2'b01, 32'h104, 32'h0, 0, 11, "f_mem_second");
    join
    @(negedge clk);
    access(0, 1, 0, 2'b01, 32'hFFFFFFFF, 32'h0, 1, 4, "t4_wrap");
    @(negedge clk);
    pre = ram[12'h303];
    mem_req = 1; mem_we = 1; mem_len = 2'b11; mem_addr = 32'h300; mem_wdata = 32'h44332211;
    repeat (3) @(negedge clk);
    chk("t5_wr_before", ram_wr, 1);
    chk("t5_addr_before", ram_addr, 32'h302);
    rst = 1; mem_req = 0;
    @(negedge clk);
    chk("t5_wr_after", ram_wr, 0);
    chk("t5_no_done", mem_done, 0);
    rst = 0;
    @(negedge clk);
    chk("t5_kept", ram[12'h300], 8'h11);
    chk("t5_untouched", ram[12'h303], pre);
    access(0, 1, 0, 2'b11, 32'h400, 32'h0, 1, 6, "t5_read");
    @(negedge clk);
    sb[1].push_back(model_rd(32'h500, 4));
    mem_req = 1; mem_we = 0; mem_len = 2'b11; mem_addr = 32'h500;
    pulses = 0; dcyc = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n <= 4) chk("t6_addr", ram_addr, 32'h500 + 32'(n - 1));
      if (n == 2) begin mem_addr = 32'h600; mem_req = 0; end
      if (mem_done) begin pulses++; dcyc = n; end
    end
    chk("t6_pulses", pulses, 1);
    chk("t6_cycle", dcyc, 6);
    chk("sb_left", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
